// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if
//   Request/response bundle for the multi-cycle execute unit.
//   Request side : in_valid, in_ready, Operation, SrcA, SrcB
//   Response side: out_valid, out_ready, ALUResult, Zero
//   master modport: the requester/consumer that talks to the unit.
//   slave modport : the execute unit itself.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Registered multi-cycle execute unit. Single-step ops finish in one
//   cycle; shifts iterate one bit per cycle; with MULT_EN defined, code
//   1100 runs an unsigned shift-add multiply over WIDTH cycles.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - multicycle_alu_if.slave (valid/ready request and response)
//   Optional feature macro: MULT_EN (undefined: 1100 is an undefined code).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | in_ready high, waiting for a request
//   SHIFT | one-bit shift per cycle, counter holds remaining positions
//   MUL   | one shift-add step per cycle (MULT_EN builds only)
//   DONE  | out_valid high, result held until out_ready
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_alu_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_NE   = 4'b1011;
`ifdef MULT_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;      // shift register / MUL accumulator
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
`ifdef MULT_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mul_sum;
`endif

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;
    logic             is_shift;
    logic [SH_W-1:0]  shamt;

    assign shamt    = bus.SrcB[SH_W-1:0];
    assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                      (bus.Operation == OP_SRA);

    always_comb begin
        alu_res = '0;
        case (bus.Operation)
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
            OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA != bus.SrcB};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
            default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

`ifdef MULT_EN
    assign mul_sum = work_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
`ifdef MULT_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.Operation;
                    if (is_shift && shamt != '0) begin
                        work_d  = bus.SrcA;
                        cnt_d   = CNT_W'(shamt);
                        state_d = SHIFT;
                    end else if (is_shift) begin
                        result_d    = bus.SrcA;
                        zero_d      = (bus.SrcA == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
`ifdef MULT_EN
                    end else if (bus.Operation == OP_MUL) begin
                        work_d   = '0;
                        mcand_d  = bus.SrcA;
                        mplier_d = bus.SrcB;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = MUL;
`endif
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = shifted;
                    zero_d      = (shifted == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
`ifdef MULT_EN
            MUL: begin
                work_d   = mul_sum;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = mul_sum;
                    zero_d      = (mul_sum == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MULT_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
`ifdef MULT_EN
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          lat;
        int          hold;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    multicycle_alu_if #(.WIDTH(32)) bus();

    multicycle_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired, required event not seen", name);
    endtask

    // Issue one request; the expected response is queued for the monitor.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input int lat, input int hold, input bit expect_out);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_now({name, "_accept"});
            return;
        end
        bus.in_valid  = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        @(posedge clk);
        #1;
        // Scramble inputs: captured operands must be used from here on.
        bus.in_valid  = 1'b0;
        bus.Operation = 4'b0010;
        bus.SrcA      = 32'hDEAD_BEEF;
        bus.SrcB      = 32'h0000_0003;
        if (expect_out) begin
            e.res = res; e.zero = z; e.lat = lat; e.hold = hold;
            e.acc_cyc = cyc; e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid || !bus.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now({name, "_idle"});
    endtask

    // Reset while an SRL by 31 is in flight; prior result/Zero must hold until then.
    task automatic mid_reset(input logic [31:0] prev_res, input logic prev_z);
        issue("srl31", 4'b0101, 32'hFFFF_FFFF, 32'd31, 32'h0, 1'b0, 0, 0, 1'b0);
        repeat (9) @(negedge clk);
        chk("midshift_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midshift_result_held", bus.ALUResult, prev_res);
        chk("midshift_zero_held", 32'(bus.Zero), 32'(prev_z));
        chk("midshift_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.ALUResult, 32'h0);
        chk("rst_zero", 32'(bus.Zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_no_output", 32'(bus.out_valid), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t e;
        int   lat;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no output", bus.ALUResult);
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc_cyc + 1;
                    chk({e.name, "_latency"}, 32'(lat), 32'(e.lat));
                    chk({e.name, "_result"}, bus.ALUResult, e.res);
                    chk({e.name, "_zero"}, 32'(bus.Zero), 32'(e.zero));
                    chk({e.name, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
                    for (int i = 0; i < e.hold; i++) begin
                        @(negedge clk);
                        chk({e.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                        chk({e.name, "_hold_result"}, bus.ALUResult, e.res);
                        chk({e.name, "_hold_zero"}, 32'(bus.Zero), 32'(e.zero));
                        chk({e.name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
                    end
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    chk({e.name, "_handoff_valid"}, 32'(bus.out_valid), 32'd0);
                    chk({e.name, "_handoff_in_ready"}, 32'(bus.in_ready), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.Operation = 4'b0000;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.ALUResult, 32'h0);
        chk("reset_zero", 32'(bus.Zero), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        //     name     op       SrcA           SrcB           result         Z    lat hold
        issue("add",   4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1, 3, 1'b1);
        issue("sub0",  4'b0110, 32'd9,         32'd9,         32'd0,         1'b1, 1, 0, 1'b1);
        issue("subw",  4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1, 0, 1'b1);
        issue("sra4",  4'b0111, 32'h8000_0010, 32'd4,         32'hF800_0001, 1'b0, 5, 0, 1'b1);
        issue("sll0",  4'b0100, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 1, 0, 1'b1);
        issue("sll33", 4'b0100, 32'h0000_0001, 32'd33,        32'h0000_0002, 1'b0, 2, 0, 1'b1);
        issue("srl31", 4'b0101, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32, 0, 1'b1);
        issue("srl8",  4'b0101, 32'h8000_0000, 32'd8,         32'h0080_0000, 1'b0, 9, 1, 1'b1);
        issue("slt",   4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1, 0, 1'b1);
        issue("slt_r", 4'b1000, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1, 0, 1'b1);
        issue("sltu",  4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1, 0, 1'b1);
        issue("eq",    4'b1010, 32'd3,         32'd3,         32'd1,         1'b0, 1, 0, 1'b1);
        issue("and",   4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 0, 1'b1);
        issue("or",    4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1, 0, 1'b1);
        issue("xor",   4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1, 0, 1'b1);
        issue("undef", 4'b1111, 32'd7,         32'd9,         32'd0,         1'b1, 1, 0, 1'b1);
`ifdef MULT_EN
        issue("mul",   4'b1100, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 33, 0, 1'b1);
        issue("mul2",  4'b1100, 32'd6,         32'd7,         32'd42,        1'b0, 33, 0, 1'b1);
`else
        issue("mul",   4'b1100, 32'h0000_FFFF, 32'h0001_0001, 32'd0,         1'b1, 1, 0, 1'b1);
`endif
        issue("ne",    4'b1011, 32'd3,         32'd3,         32'd0,         1'b1, 1, 0, 1'b1);
        wait_idle("ne");
        mid_reset(32'h0, 1'b1);
        issue("add11", 4'b0010, 32'd1,         32'd1,         32'd2,         1'b0, 1, 0, 1'b1);
        issue("subw2", 4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1, 0, 1'b1);
        wait_idle("subw2");
        mid_reset(32'hFFFF_FFFF, 1'b0);
        issue("add_f", 4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1, 0, 1'b1);
        wait_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Registered, multi-cycle execute unit.
- Consumes the 4-bit Operation code produced by the ALU controller, plus the two operands.
- Returns the ALU result and Zero flag over a valid/ready handshake.
- Shifts (and optionally multiply) run iteratively at one bit per cycle; the datapath stalls via the handshake instead of using a barrel shifter.

Parameters:
- WIDTH, 32, operand/result width in bits (shift amount is SrcB[$clog2(WIDTH)-1:0]).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request carries a valid Operation/SrcA/SrcB.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- Operation  input  4  operation select from the ALU controller.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B / shift amount.
- out_valid  output  1  ALUResult/Zero are valid.
- out_ready  input  1  consumer takes the result.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered, equals (ALUResult == 0).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, ALUResult=0, Zero=0, internal counter=0. in_ready=1 once reset deasserts.
- Accept:
  - Request accepted on a clk edge with in_valid && in_ready.
  - Operation, SrcA and SrcB are captured; later input changes are ignored.
- Operation codes:
  - 0000 AND, 0001 OR, 0011 XOR.
  - 0010 ADD, 0110 SUB (both wrap modulo 2^WIDTH).
  - 1000 SLT signed, 1001 SLTU unsigned (result 1 or 0, zero-extended).
  - 1010 EQ (A==B → 1), 1011 NE.
  - 0100 SLL, 0101 SRL, 0111 SRA.
  - 1100 MUL (see Optional Feature).
  - All other codes: ALUResult=0, Zero=1, latency 1.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept, logic/arith/compare ops → DONE with result loaded. Shift with shamt≠0 → SHIFT with counter=shamt. Shift with shamt=0 → DONE, result=SrcA.
  - SHIFT: shift the working register one position per cycle and decrement the counter. SRA replicates the MSB; SRL/SLL insert 0. When counter reaches 1 on an edge, the final shift is applied and the FSM goes to DONE.
  - MUL (only with MULT_EN): one shift-add step per cycle for WIDTH cycles, then DONE.
  - DONE: out_valid=1; ALUResult and Zero stay stable while out_ready=0. On out_valid && out_ready → IDLE, out_valid=0.
- Latency (accept edge to out_valid high):
  - 1 cycle for single-step ops and shamt=0.
  - shamt+1 cycles for shifts.
  - WIDTH+1 cycles for MUL.
- Throughput: at most one op per 2 cycles. There is no accept in the same cycle as the DONE→IDLE handoff, because in_ready=0 in DONE.
- Zero: computed from the final result and registered with it. Never updated in SHIFT/MUL; it holds the previous value until DONE.
- Mid-operation reset: aborts immediately to the reset values. The partial result is discarded.
- shamt uses only the low $clog2(WIDTH) bits of SrcB; upper bits are ignored (SrcB=33 with WIDTH=32 → shift by 1).

Optional Feature:
- Macro MULT_EN.
- Defined: code 1100 performs unsigned shift-add multiply.
  - Each MUL cycle: if the multiplier LSB is set, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right.
  - Result = low WIDTH bits of SrcA*SrcB.
  - Latency WIDTH+1; mid-op reset aborts.
- Undefined: no MUL state or accumulator is built; 1100 behaves as an undefined code (ALUResult=0, Zero=1, latency 1).

Test Plan:
- Reset then ADD: SrcA=5, SrcB=7, Op 0010 → out_valid 1 cycle after accept; ALUResult=12, Zero=0. Hold out_ready=0 for 3 cycles → values stable and in_ready=0.
- SUB giving zero and wrap: 9−9 → ALUResult=0, Zero=1. Then 0−1 → ALUResult=0xFFFFFFFF.
- SRA: SrcA=0x80000010, SrcB=4, Op 0111 → out_valid 5 cycles after accept; ALUResult=0xF8000001. Then SLL with SrcB=0 → ALUResult=SrcA, latency 1.
- Compares: SLT(−1, 1)=1; SLTU(0xFFFFFFFF, 1)=0; EQ(3, 3)=1; NE(3, 3)=0 with Zero=1.
- Mid-shift reset: SRL with SrcB=31; assert reset on cycle 10 → immediately out_valid=0, ALUResult=0, Zero=0. After release, in_ready=1 and ADD(1, 1)=2 completes normally.
- MULT_EN: MUL(0x0000FFFF, 0x00010001) → 0xFFFFFFFF after 33 cycles. Without MULT_EN → ALUResult=0, Zero=1 after 1 cycle.
